// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32 load/store port: byte-lane RAM, programmable wait states,
// range/size checks. Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memSize,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned Words = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Words];

  logic                  accept, do_access, do_write;
  logic [31:0]           off, wshift, rword, rshift, rmasked;
  logic                  in_range, misalign, access_err;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;

  assign accept = (state_q == StIdle) && i_req;

  // Address decode and lane selection on the latched request.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    in_range = (off >> (ADDR_WIDTH + 2)) == '0;
    idx      = off[ADDR_WIDTH+1:2];
`ifdef DMEM_MISALIGN_ERR_EN
    lane     = off[1:0];
    misalign = ((size_q == 2'b01) && off[0]) || ((size_q == 2'b10) && (off[1:0] != 2'b00));
`else
    misalign = 1'b0;
    case (size_q)
      2'b01:   lane = {off[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = off[1:0];
    endcase
`endif
    access_err = !in_range || (size_q == 2'b11) || misalign;

    case (size_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    wshift = wdata_q << {lane, 3'b000};

    rword  = mem[idx];
    rshift = rword >> {lane, 3'b000};
    case (size_q)
      2'b00:   rmasked = {24'b0, rshift[7:0]};
      2'b01:   rmasked = {16'b0, rshift[15:0]};
      default: rmasked = rshift;
    endcase
  end

  assign do_access = (state_q == StWait) && (cnt_q == 4'd0);
  assign do_write  = do_access && write_q && !access_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          err_d   = access_err;
          rdata_d = (access_err || write_q) ? 32'h0 : rmasked;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= i_write;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        size_q  <= i_memSize;
      end
    end
  end

  // RAM is never reset; a reset sampled on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StResp);
  assign o_rdata = rdata_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle corner sequences
// and randomized traffic against a byte-array reference model. Instances use LATENCY 1, 4, 3.
module tb_dmem_responder;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic [2:0]  rst, req, wr;
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [1:0]  sz [3];
  logic [2:0]  ready, valid, err;
  logic [31:0] rdata [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [64];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut0 (
    .clk(clk), .reset(rst[0]), .i_req(req[0]), .i_write(wr[0]), .i_addr(addr[0]),
    .i_wdata(wd[0]), .i_memSize(sz[0]), .o_ready(ready[0]), .o_valid(valid[0]),
    .o_rdata(rdata[0]), .o_err(err[0])
  );
  dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .i_req(req[1]), .i_write(wr[1]), .i_addr(addr[1]),
    .i_wdata(wd[1]), .i_memSize(sz[1]), .o_ready(ready[1]), .o_valid(valid[1]),
    .o_rdata(rdata[1]), .o_err(err[1])
  );
  dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .LATENCY(3)) u_dut2 (
    .clk(clk), .reset(rst[2]), .i_req(req[2]), .i_write(wr[2]), .i_addr(addr[2]),
    .i_wdata(wd[2]), .i_memSize(sz[2]), .o_ready(ready[2]), .o_valid(valid[2]),
    .o_rdata(rdata[2]), .o_err(err[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One complete transaction; checks response latency, ready-low span and strobe width.
  task automatic run_op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, output logic [31:0] rd, output logic e);
    int n;
    int c;
    int lowc;
    rd = '0;
    e  = 1'b0;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wd[k] = d; sz[k] = s;
    n = 0;
    while (!ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready[k]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready stayed 0 for %0d cycles, required 1", n);
      req[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Inputs change after accept; the latched request must be used.
    req[k] = 1'b0; wr[k] = 1'($urandom); addr[k] = $urandom; wd[k] = $urandom;
    sz[k] = 2'($urandom);
    c    = 0;
    lowc = 0;
    do begin
      @(negedge clk);
      c++;
      if (!ready[k]) lowc++;
    end while (!valid[k] && c < 40);
    check("latency", 32'(c), 32'(lat_of(k) + 1));
    check("ready_low", 32'(lowc), 32'(lat_of(k) + 1));
    rd = rdata[k];
    e  = err[k];
    @(negedge clk);
    check("strobe_width", {31'b0, valid[k]}, 32'd0);
    check("ready_after", {31'b0, ready[k]}, 32'd1);
  endtask

  // Reference: memory as bytes over window 0x100..0x13F, access rules applied directly.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output logic [31:0] rd, output logic e);
    int nb;
    logic [31:0] ae;
    nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    rd = '0;
    e  = (a >= 32'h0001_0000) || (s == 2'b11);
    ae = a;
`ifdef DMEM_MISALIGN_ERR_EN
    if ((a & 32'(nb - 1)) != 32'h0) e = 1'b1;
`else
    ae = a & ~32'(nb - 1);
`endif
    if (!e) begin
      for (int b = 0; b < nb; b++) begin
        if (w) mm[int'(ae - 32'h100) + b] = d[8*b +: 8];
        else   rd[8*b +: 8] = mm[int'(ae - 32'h100) + b];
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv [17];
    logic [31:0] rd, mrd, a;
    logic        e, me, w;
    logic [1:0]  s;
    int          vc, rc, run, maxlow, lastv, gapbad;

    tv[0]  = '{1'b1, 32'h10,    32'hDEADBEEF, 2'b10, 32'h0,        1'b0};
    tv[1]  = '{1'b0, 32'h10,    32'h0,        2'b10, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 32'h11,    32'h123456AB, 2'b00, 32'h0,        1'b0};
    tv[3]  = '{1'b0, 32'h10,    32'h0,        2'b10, 32'hDEADABEF, 1'b0};
    tv[4]  = '{1'b0, 32'h12,    32'h0,        2'b01, 32'h0000DEAD, 1'b0};
    tv[5]  = '{1'b0, 32'h13,    32'h0,        2'b00, 32'h000000DE, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    tv[6]  = '{1'b0, 32'h11,    32'h0,        2'b01, 32'h0,        1'b1};
`else
    tv[6]  = '{1'b0, 32'h11,    32'h0,        2'b01, 32'h0000ABEF, 1'b0};
`endif
    tv[7]  = '{1'b0, 32'h10000, 32'h0,        2'b10, 32'h0,        1'b1};
    tv[8]  = '{1'b1, 32'h10,    32'h0,        2'b11, 32'h0,        1'b1};
    tv[9]  = '{1'b1, 32'h10010, 32'h0,        2'b10, 32'h0,        1'b1};
    tv[10] = '{1'b0, 32'h10,    32'h0,        2'b10, 32'hDEADABEF, 1'b0};
    tv[11] = '{1'b1, 32'h14,    32'hA5A5A5A5, 2'b10, 32'h0,        1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    tv[12] = '{1'b1, 32'h15,    32'h11223344, 2'b10, 32'h0,        1'b1};
    tv[13] = '{1'b1, 32'h17,    32'h0000BEEF, 2'b01, 32'h0,        1'b1};
    tv[14] = '{1'b0, 32'h14,    32'h0,        2'b10, 32'hA5A5A5A5, 1'b0};
`else
    tv[12] = '{1'b1, 32'h15,    32'h11223344, 2'b10, 32'h0,        1'b0};
    tv[13] = '{1'b1, 32'h17,    32'h0000BEEF, 2'b01, 32'h0,        1'b0};
    tv[14] = '{1'b0, 32'h14,    32'h0,        2'b10, 32'hBEEF3344, 1'b0};
`endif
    tv[15] = '{1'b1, 32'hFFFF,  32'hFFFFFF5A, 2'b00, 32'h0,        1'b0};
    tv[16] = '{1'b0, 32'hFFFF,  32'h0,        2'b00, 32'h0000005A, 1'b0};

    rst = 3'b111; req = 3'b000; wr = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wd[k] = '0; sz[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), {31'b0, ready[k]}, 32'd1);
      check($sformatf("reset_valid%0d", k), {31'b0, valid[k]}, 32'd0);
      check($sformatf("reset_rdata%0d", k), rdata[k], 32'h0);
      check($sformatf("reset_err%0d", k), {31'b0, err[k]}, 32'd0);
    end
    rst = 3'b000;

    for (int i = 0; i < 17; i++) begin
      run_op(0, tv[i].w, tv[i].a, tv[i].d, tv[i].s, rd, e);
      check($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tv[i].exp_err});
    end

    // Request held continuously on the LATENCY=4 instance.
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; sz[1] = 2'b10;
    vc = 0; rc = 0; run = 0; maxlow = 0; lastv = -1; gapbad = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (valid[1]) begin
        vc++;
        if (lastv >= 0 && i - lastv != 6) gapbad++;
        lastv = i;
      end
      if (ready[1]) begin
        rc++;
        run = 0;
      end else begin
        run++;
        if (run > maxlow) maxlow = run;
      end
    end
    req[1] = 1'b0;
    check("b2b_responses", 32'(vc), 32'd6);
    check("b2b_ready_cycles", 32'(rc), 32'd6);
    check("b2b_ready_low_run", 32'(maxlow), 32'd5);
    check("b2b_spacing", 32'(gapbad), 32'd0);

    // Reset one cycle after accepting a store on the LATENCY=3 instance.
    run_op(2, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, rd, e);
    run_op(2, 1'b0, 32'h20, 32'h0, 2'b10, rd, e);
    check("pre_reset_load", rd, 32'hCAFEF00D);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h20; wd[2] = 32'h12345678; sz[2] = 2'b10;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    check("midreset_ready", {31'b0, ready[2]}, 32'd1);
    check("midreset_valid", {31'b0, valid[2]}, 32'd0);
    check("midreset_rdata", rdata[2], 32'h0);
    check("midreset_err", {31'b0, err[2]}, 32'd0);
    rst[2] = 1'b0;
    vc = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid[2]) vc++;
    end
    check("midreset_no_valid", 32'(vc), 32'd0);
    run_op(2, 1'b0, 32'h20, 32'h0, 2'b10, rd, e);
    check("post_reset_load", rd, 32'hCAFEF00D);

    // Randomized traffic over a 64-byte window plus out-of-range addresses.
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(4 * i);
      model(1'b1, a, $urandom, 2'b10, mrd, me);
      run_op(0, 1'b1, a, {mm[4*i+3], mm[4*i+2], mm[4*i+1], mm[4*i]}, 2'b10, rd, e);
    end
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom);
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'h0001_0000 + $urandom_range(0, 1023);
      else                           a = 32'h100 + $urandom_range(0, 63);
      wd[0] = $urandom;
      mrd = wd[0];
      run_op(0, w, a, mrd, s, rd, e);
      model(w, a, mrd, s, mrd, me);
      check($sformatf("rand%0d_rdata a=%08h s=%0d w=%0d", i, a, s, w), rd, mrd);
      check($sformatf("rand%0d_err a=%08h s=%0d w=%0d", i, a, s, w), {31'b0, e}, {31'b0, me});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
